// File: rtl/rx_control.sv
// rx_control: receive-side bit sequencer for an I2C slave data path.
//   clk, rstn       system clock, asynchronous active-low reset
//   SCL, SDAIn      raw I2C bus lines (asynchronous to clk)
//   StartRX, Size   start pulse and byte count (clamped to 1..4)
//   Abort           level, drops the transfer without committing it
//   RXIn, RXcount   sampled data bit and its MSB-first bit index
//   ValidRXDIn      one-clk strobe per new RXIn/RXcount pair
//   StartRX2        high while bits are being delivered
//   LatchRXD0/1     selects the shifter buffer for this transfer
//   SDAOE           pull SDA low (ACK)
//   RXDone          one-clk strobe on a committed transfer
//   Busy            FSM not idle
module rx_control #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SCL,
    input  logic       SDAIn,
    input  logic       StartRX,
    input  logic       Abort,
    input  logic [3:0] Size,
    output logic       RXIn,
    output logic       StartRX2,
    output logic [6:0] RXcount,
    output logic       LatchRXD0,
    output logic       LatchRXD1,
    output logic       ValidRXDIn,
    output logic       SDAOE,
    output logic       RXDone,
    output logic       Busy
);
    typedef enum logic [2:0] {IDLE, WAIT_LOW, BIT, ACK, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall;
    logic [1:0]             size_q, size_d, byte_q, byte_d, ack_ph_q, ack_ph_d;
    logic [2:0]             bit_q, bit_d;
    logic [6:0]             rxcount_q, rxcount_d;
    logic                   rxin_q, rxin_d, valid_q, valid_d;
    logic                   sdaoe_q, sdaoe_d, sel_q, sel_d;
    logic                   last_byte, abort_act;

    // Synchronizers idle high so a reset never looks like an SCL edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDAIn};
            scl_prev_q <= scl_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign last_byte = byte_q == size_q;
    assign abort_act = Abort && state_q != IDLE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = StartRX ? WAIT_LOW : IDLE;
            WAIT_LOW: state_d = !scl_s ? BIT : WAIT_LOW;
            BIT:      state_d = (scl_rise && bit_q == 3'd7) ? ACK : BIT;
            ACK:      state_d = (scl_fall && ack_ph_q == 2'd2) ? (last_byte ? COMMIT : BIT) : ACK;
            default:  state_d = IDLE;
        endcase
        if (abort_act) state_d = IDLE;
    end

    // ack_ph: 0 = wait fall after 8th bit, 1 = wait 9th rise, 2 = wait closing fall.
    always_comb begin
        size_d    = size_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        ack_ph_d  = ack_ph_q;
        rxin_d    = rxin_q;
        rxcount_d = rxcount_q;
        valid_d   = 1'b0;
        sdaoe_d   = sdaoe_q;
        sel_d     = sel_q;
        if (abort_act) begin
            sdaoe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (StartRX) begin
                    size_d   = (Size == 4'd0) ? 2'd0 : (Size > 4'd4) ? 2'd3 : Size[1:0] - 2'd1;
                    byte_d   = 2'd0;
                    bit_d    = 3'd0;
                    ack_ph_d = 2'd0;
                end
                BIT: if (scl_rise) begin
                    rxin_d    = sda_s;
                    rxcount_d = {2'b00, byte_q, bit_q};
                    valid_d   = 1'b1;
                    bit_d     = bit_q + 3'd1;
                    ack_ph_d  = 2'd0;
                end
                ACK: begin
                    if (scl_fall && ack_ph_q == 2'd0) begin
                        sdaoe_d  = !last_byte;
                        ack_ph_d = 2'd1;
                    end else if (scl_rise && ack_ph_q == 2'd1) begin
                        ack_ph_d = 2'd2;
                    end else if (scl_fall && ack_ph_q == 2'd2) begin
                        sdaoe_d   = 1'b0;
                        byte_d    = byte_q + 2'd1;
                        rxcount_d = last_byte ? 7'd0 : rxcount_q;
                    end
                end
                COMMIT: sel_d = ~sel_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            size_q    <= 2'd0;
            byte_q    <= 2'd0;
            bit_q     <= 3'd0;
            ack_ph_q  <= 2'd0;
            rxin_q    <= 1'b0;
            rxcount_q <= 7'd0;
            valid_q   <= 1'b0;
            sdaoe_q   <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            size_q    <= size_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            ack_ph_q  <= ack_ph_d;
            rxin_q    <= rxin_d;
            rxcount_q <= rxcount_d;
            valid_q   <= valid_d;
            sdaoe_q   <= sdaoe_d;
            sel_q     <= sel_d;
        end
    end

    always_comb begin
        Busy      = state_q != IDLE;
        StartRX2  = state_q == BIT || state_q == ACK;
        LatchRXD0 = Busy && !sel_q;
        LatchRXD1 = Busy && sel_q;
        RXDone    = state_q == COMMIT;
    end

    assign RXIn       = rxin_q;
    assign RXcount    = rxcount_q;
    assign ValidRXDIn = valid_q;
    assign SDAOE      = sdaoe_q;
endmodule

// File: tb/tb_rx_control.sv
// tb_rx_control: drives I2C-like byte traffic into rx_control and checks it against a bit-list model.
module tb_rx_control;
    localparam int H = 8;

    logic       clk = 1'b0, rstn = 1'b0, SCL = 1'b1, SDAIn = 1'b1, StartRX = 1'b0, Abort = 1'b0;
    logic [3:0] Size = 4'd0;
    logic       RXIn, StartRX2, LatchRXD0, LatchRXD1, ValidRXDIn, SDAOE, RXDone, Busy;
    logic [6:0] RXcount;

    int         total = 0, bad = 0;
    logic [7:0] data [4];
    logic       got_bit [$];
    int         got_idx [$];
    logic       ack_obs [$];
    int         done_cnt = 0;
    logic       done_l0 = 1'b0, done_l1 = 1'b0, done_s2 = 1'b0;
    logic [6:0] done_rc = 7'd0;
    logic       lat0_run, lat1_run;
    logic       model_sel = 1'b0;

    always #5 clk = ~clk;

    rx_control #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .SCL(SCL), .SDAIn(SDAIn), .StartRX(StartRX), .Abort(Abort),
        .Size(Size), .RXIn(RXIn), .StartRX2(StartRX2), .RXcount(RXcount), .LatchRXD0(LatchRXD0),
        .LatchRXD1(LatchRXD1), .ValidRXDIn(ValidRXDIn), .SDAOE(SDAOE), .RXDone(RXDone), .Busy(Busy)
    );

    always @(negedge clk) begin
        if (ValidRXDIn) begin
            got_bit.push_back(RXIn);
            got_idx.push_back(int'(RXcount));
        end
        if (RXDone) begin
            done_cnt = done_cnt + 1;
            done_l0  = LatchRXD0;
            done_l1  = LatchRXD1;
            done_rc  = RXcount;
            done_s2  = StartRX2;
        end
    end

    function automatic int eff(input logic [3:0] s);
        return (s == 4'd0) ? 1 : (s > 4'd4) ? 4 : int'(s);
    endfunction

    task automatic run_xfer(input logic [3:0] sz, input int nb, input int abort_after, input bit stop_in_ack);
        int bits = 0;
        @(negedge clk);
        Size = sz;
        StartRX = 1'b1;
        @(negedge clk);
        StartRX = 1'b0;
        Size = 4'($urandom);
        lat0_run = LatchRXD0;
        lat1_run = LatchRXD1;
        repeat (2) @(negedge clk);
        for (int j = 0; j < nb; j++) begin
            for (int i = 7; i >= 0; i--) begin
                SCL = 1'b0;
                SDAIn = data[j][i];
                repeat (H) @(negedge clk);
                SCL = 1'b1;
                repeat (H) @(negedge clk);
                bits++;
                if (bits == abort_after) begin
                    Abort = 1'b1;
                    @(negedge clk);
                    Abort = 1'b0;
                    return;
                end
            end
            SCL = 1'b0;
            SDAIn = 1'b1;
            repeat (H) @(negedge clk);
            SCL = 1'b1;
            repeat (H / 2) @(negedge clk);
            ack_obs.push_back(SDAOE);
            if (stop_in_ack) return;
            repeat (H / 2) @(negedge clk);
        end
        SCL = 1'b0;
        repeat (H) @(negedge clk);
        SCL = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({RXIn, StartRX2, RXcount, LatchRXD0, LatchRXD1, ValidRXDIn, SDAOE, RXDone, Busy} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {RXIn, StartRX2, RXcount, LatchRXD0, LatchRXD1, ValidRXDIn, SDAOE, RXDone, Busy});
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort;
        int b0 = got_idx.size();
        int d0 = done_cnt;
        data[0] = 8'($urandom);
        run_xfer(4'd1, 1, 6, 1'b0);
        total++;
        if ({Busy, StartRX2, LatchRXD0, LatchRXD1, SDAOE} !== 5'd0) begin
            bad++;
            $display("FAIL abort_idle: got %b want 00000", {Busy, StartRX2, LatchRXD0, LatchRXD1, SDAOE});
        end
        repeat (20) @(negedge clk);
        total++;
        if (got_idx.size() - b0 !== 6) begin
            bad++;
            $display("FAIL abort_pulses: got %0d want 6", got_idx.size() - b0);
        end
        total++;
        if (done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0);
        end
    endtask

    task automatic test_single_byte;
        int b0 = got_idx.size();
        int a0 = ack_obs.size();
        int d0 = done_cnt;
        int n  = 8 * eff(4'd1);
        data[0] = 8'hA5;
        run_xfer(4'd1, 1, 0, 1'b0);
        total++;
        if (got_idx.size() - b0 !== n) begin
            bad++;
            $display("FAIL single_count: got %0d want %0d", got_idx.size() - b0, n);
        end
        for (int k = 0; k < n && b0 + k < got_idx.size(); k++) begin
            total++;
            if (got_bit[b0+k] !== data[k/8][7-k%8] || got_idx[b0+k] !== k) begin
                bad++;
                $display("FAIL single_bit%0d: got bit=%b idx=%0d want bit=%b idx=%0d",
                         k, got_bit[b0+k], got_idx[b0+k], data[k/8][7-k%8], k);
            end
        end
        total++;
        if (ack_obs[a0] !== 1'b0) begin
            bad++;
            $display("FAIL single_nack: got SDAOE=%b want 0", ack_obs[a0]);
        end
        total++;
        if (done_cnt - d0 !== 1 || {done_l0, done_l1} !== {!model_sel, model_sel} ||
            done_rc !== 7'd0 || done_s2 !== 1'b0) begin
            bad++;
            $display("FAIL single_commit: got done=%0d latch=%b%b rc=%0d s2=%b want 1 %b%b 0 0",
                     done_cnt - d0, done_l0, done_l1, done_rc, done_s2, !model_sel, model_sel);
        end
        model_sel = ~model_sel;
        total++;
        if (SDAOE !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL single_end_idle: got SDAOE=%b Busy=%b want 0 0", SDAOE, Busy);
        end
    endtask

    task automatic test_two_bytes;
        int b0 = got_idx.size();
        int a0 = ack_obs.size();
        int d0 = done_cnt;
        int mx = -1;
        data[0] = 8'h3C;
        data[1] = 8'hFF;
        run_xfer(4'd2, 2, 0, 1'b0);
        total++;
        if ({ack_obs[a0], ack_obs[a0+1]} !== 2'b10) begin
            bad++;
            $display("FAIL two_ack: got %b%b want 10", ack_obs[a0], ack_obs[a0+1]);
        end
        for (int k = b0; k < got_idx.size(); k++) mx = got_idx[k] > mx ? got_idx[k] : mx;
        total++;
        if (mx !== 15 || got_idx.size() - b0 !== 16) begin
            bad++;
            $display("FAIL two_count: got max=%0d n=%0d want 15 16", mx, got_idx.size() - b0);
        end
        for (int k = 0; k < 16 && b0 + k < got_idx.size(); k++) begin
            total++;
            if (got_bit[b0+k] !== data[k/8][7-k%8] || got_idx[b0+k] !== k) begin
                bad++;
                $display("FAIL two_bit%0d: got bit=%b idx=%0d want bit=%b idx=%0d",
                         k, got_bit[b0+k], got_idx[b0+k], data[k/8][7-k%8], k);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || {done_l0, done_l1} !== {!model_sel, model_sel}) begin
            bad++;
            $display("FAIL two_commit: got done=%0d latch=%b%b want 1 %b%b",
                     done_cnt - d0, done_l0, done_l1, !model_sel, model_sel);
        end
        model_sel = ~model_sel;
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 2; t++) begin
            int d0 = done_cnt;
            data[0] = 8'($urandom);
            run_xfer(4'd1, 1, 0, 1'b0);
            total++;
            if ({lat0_run, lat1_run} !== {!model_sel, model_sel} || done_cnt - d0 !== 1 ||
                {done_l0, done_l1} !== {!model_sel, model_sel}) begin
                bad++;
                $display("FAIL b2b_latch%0d: got run=%b%b done=%0d at=%b%b want %b%b 1",
                         t, lat0_run, lat1_run, done_cnt - d0, done_l0, done_l1, !model_sel, model_sel);
            end
            model_sel = ~model_sel;
        end
    endtask

    task automatic test_size_clamp;
        logic [3:0] sizes [2];
        sizes[0] = 4'd0;
        sizes[1] = 4'd9;
        for (int s = 0; s < 2; s++) begin
            int b0 = got_idx.size();
            int a0 = ack_obs.size();
            int d0 = done_cnt;
            int n  = 8 * eff(sizes[s]);
            for (int j = 0; j < 4; j++) data[j] = 8'($urandom);
            run_xfer(sizes[s], n / 8, 0, 1'b0);
            total++;
            if (got_idx.size() - b0 !== n || done_cnt - d0 !== 1) begin
                bad++;
                $display("FAIL clamp_size%0d: got pulses=%0d done=%0d want %0d 1",
                         sizes[s], got_idx.size() - b0, done_cnt - d0, n);
            end
            for (int k = 0; k < n && b0 + k < got_idx.size(); k++) begin
                total++;
                if (got_bit[b0+k] !== data[k/8][7-k%8] || got_idx[b0+k] !== k) begin
                    bad++;
                    $display("FAIL clamp_size%0d_bit%0d: got bit=%b idx=%0d want bit=%b idx=%0d",
                             sizes[s], k, got_bit[b0+k], got_idx[b0+k], data[k/8][7-k%8], k);
                end
            end
            for (int j = 0; j < n / 8; j++) begin
                total++;
                if (ack_obs[a0+j] !== (j < n / 8 - 1)) begin
                    bad++;
                    $display("FAIL clamp_size%0d_ack%0d: got %b want %b",
                             sizes[s], j, ack_obs[a0+j], j < n / 8 - 1);
                end
            end
            model_sel = ~model_sel;
        end
    endtask

    task automatic test_reset_mid_ack;
        int b0, d0;
        data[0] = 8'($urandom);
        data[1] = 8'($urandom);
        run_xfer(4'd2, 2, 0, 1'b1);
        total++;
        if (ack_obs[ack_obs.size()-1] !== 1'b1) begin
            bad++;
            $display("FAIL rst_ack_pre: got SDAOE=%b want 1", ack_obs[ack_obs.size()-1]);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({RXIn, StartRX2, RXcount, LatchRXD0, LatchRXD1, ValidRXDIn, SDAOE, RXDone, Busy} !== 15'd0) begin
            bad++;
            $display("FAIL rst_ack_outputs: got %b want all zero",
                     {RXIn, StartRX2, RXcount, LatchRXD0, LatchRXD1, ValidRXDIn, SDAOE, RXDone, Busy});
        end
        SCL = 1'b1;
        SDAIn = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_sel = 1'b0;
        repeat (2) @(negedge clk);
        b0 = got_idx.size();
        d0 = done_cnt;
        data[0] = 8'($urandom);
        run_xfer(4'd1, 1, 0, 1'b0);
        total++;
        if (got_idx.size() - b0 !== 8 || done_cnt - d0 !== 1 || {done_l0, done_l1} !== 2'b10) begin
            bad++;
            $display("FAIL rst_ack_after: got pulses=%0d done=%0d latch=%b%b want 8 1 10",
                     got_idx.size() - b0, done_cnt - d0, done_l0, done_l1);
        end
        for (int k = 0; k < 8 && b0 + k < got_idx.size(); k++) begin
            total++;
            if (got_bit[b0+k] !== data[0][7-k] || got_idx[b0+k] !== k) begin
                bad++;
                $display("FAIL rst_ack_bit%0d: got bit=%b idx=%0d want bit=%b idx=%0d",
                         k, got_bit[b0+k], got_idx[b0+k], data[0][7-k], k);
            end
        end
    endtask

    initial begin
        test_reset;
        test_abort;
        test_single_byte;
        test_two_bytes;
        test_back_to_back;
        test_size_clamp;
        test_reset_mid_ack;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_control.md
RX_CONTROL -- requirements
Module: rx_control

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flops in the synchronizer chains on SCL and SDAIn (legal range 2..3).
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rstn  in  1  reset; asynchronous, active-low.
REQ-004 SCL  in  1  I2C bus clock, asynchronous to clk.
REQ-005 SDAIn  in  1  I2C data line, asynchronous to clk.
REQ-006 StartRX  in  1  one-clk pulse that begins a receive transfer.
REQ-007 Abort  in  1  level; terminates the transfer in progress without committing it.
REQ-008 Size  in  4  number of bytes to receive; sampled on the StartRX cycle.
REQ-009 RXIn  out  1  most recently sampled data bit, fed to the receive shifter.
REQ-010 StartRX2  out  1  high while data bits are being delivered to the shifter.
REQ-011 RXcount  out  7  bit index of RXIn within the transfer, MSB first (0 = first bit).
REQ-012 LatchRXD0  out  1  selects shifter buffer 0.
REQ-013 LatchRXD1  out  1  selects shifter buffer 1.
REQ-014 ValidRXDIn  out  1  one-clk pulse marking a new RXIn/RXcount pair.
REQ-015 SDAOE  out  1  when high, the pad drives SDA low (ACK).
REQ-016 RXDone  out  1  one-clk pulse on a committed transfer.
REQ-017 Busy  out  1  high in any state other than IDLE.

Function
REQ-018 SCL and SDAIn SHALL each pass through a SYNC_STAGES flop chain; the SCL edge detect SHALL use the synchronized signal and its previous value.
REQ-019 Effective size SHALL be Size clamped to 1..4: 0 is treated as 1, and values above 4 are treated as 4. Total bits N = 8*effective size.
REQ-020 The FSM SHALL have states IDLE, WAIT_LOW, BIT, ACK, COMMIT.
REQ-021 IDLE: StartRX moves the FSM to WAIT_LOW and captures the effective size. StartRX in any other state SHALL be ignored.
REQ-022 WAIT_LOW: the first synchronized SCL low moves the FSM to BIT. This prevents sampling on an SCL already high at start.
REQ-023 BIT: on each synchronized SCL rising edge, in the following cycle:
  - RXIn <= synchronized SDA;
  - RXcount <= bit index;
  - ValidRXDIn = 1 for exactly one clk.
RXIn and RXcount SHALL hold until the next sample.
REQ-024 StartRX2 SHALL be high from the WAIT_LOW->BIT transition until the COMMIT entry.
REQ-025 After the 8th bit of a byte, the FSM SHALL enter ACK.
REQ-026 In ACK, SDAOE SHALL assert on the next SCL falling edge and stay high through the 9th SCL rising edge, deasserting on the following SCL falling edge.
REQ-027 The last byte SHALL receive NACK: SDAOE stays 0 for its whole ACK slot.
REQ-028 ACK exit: go to BIT if bytes remain, otherwise to COMMIT, on the SCL falling edge after the 9th rise.
REQ-029 No ValidRXDIn pulse SHALL occur for the 9th (ACK) clock.
REQ-030 Exactly one of LatchRXD0/LatchRXD1 SHALL be high from WAIT_LOW through COMMIT, chosen by an internal buffer-select bit. Both SHALL be low in IDLE.
REQ-031 COMMIT lasts one clk:
  - StartRX2 = 0;
  - RXcount = 0;
  - the active latch stays high;
  - RXDone = 1.
The buffer-select bit SHALL then toggle, and the FSM SHALL return to IDLE.
REQ-032 Abort high in any non-IDLE state SHALL return the FSM to IDLE on the next clk, with no COMMIT, no RXDone, no select toggle, and SDAOE = 0.
REQ-033 Abort has priority over SCL events in the same cycle.
REQ-034 RXcount SHALL never exceed N-1 while StartRX2 is high.

Reset
REQ-035 While rstn = 0, all of the following SHALL be 0, asynchronously and regardless of the state at assertion (including mid-bit or mid-ACK):
  - outputs RXIn, StartRX2, RXcount, LatchRXD0, LatchRXD1, ValidRXDIn, SDAOE, RXDone, Busy;
  - FSM = IDLE;
  - buffer select = 0;
  - synchronizer flops = 1 (idle bus).
REQ-036 The first transfer after reset SHALL use LatchRXD0.

Verification
REQ-037 Size=1, byte 0xA5 on SDA -> 8 ValidRXDIn pulses with RXIn = 1,0,1,0,0,1,0,1 and RXcount 0..7; SDAOE = 0 in the ACK slot (NACK); then RXDone with LatchRXD0 = 1 and RXcount = 0.
REQ-038 Size=2, bytes 0x3C then 0xFF -> SDAOE high during the first ACK slot and low during the second; RXcount reaches 15; RXDone once.
REQ-039 Two back-to-back Size=1 transfers -> the first uses LatchRXD0, the second uses LatchRXD1.
REQ-040 Size=0 and Size=9 -> 8 and 32 ValidRXDIn pulses respectively.
REQ-041 Abort after bit 5 -> IDLE next clk, no RXDone; the next transfer still uses LatchRXD0.
REQ-042 rstn low during an ACK slot -> SDAOE = 0 immediately, all outputs 0; a subsequent Size=1 transfer completes correctly.
